fanout_capture_sched: RTL and testbench

- Sequencer for one launch register that feeds a slow buffer chain and a wide bank of capture registers.
- Treats the launch-to-capture path as a programmable multicycle path. The block accepts a launch request, drives the launch register for one cycle, then waits a configured number of cycles.
- After the wait it enables the capture registers in fixed-size groups, one group per cycle, to bound the enable fanout burst.
- Sits between the request source and the launch/capture flop bank; it is the only source of their enables.

---
 rtl/fanout_capture_sched.sv | 91 +++++++++
 tb/tb_fanout_capture_sched.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fanout_capture_sched.sv
// fanout_capture_sched: sequences one launch enable, a programmable multicycle wait, then grouped capture enables
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   req_valid/req_ready     launch request handshake (ready only in IDLE)
//   req_data, cfg_delay     launch value and wait length, both sampled at accept
//   abort                   cancels a running sequence without a done pulse
//   launch_en, launch_data  one-cycle launch enable and the held launch value
//   cap_en                  per-sink capture enables, at most GROUP_SIZE per cycle
//   busy, done              sequence active flag and normal-completion pulse
module fanout_capture_sched #(
    parameter int WIDTH      = 1,
    parameter int NUM_SINKS  = 11,
    parameter int GROUP_SIZE = 4,
    parameter int DELAY_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_data,
    input  logic [DELAY_W-1:0]   cfg_delay,
    input  logic                 abort,
    output logic                 launch_en,
    output logic [WIDTH-1:0]     launch_data,
    output logic [NUM_SINKS-1:0] cap_en,
    output logic                 busy,
    output logic                 done
);
    localparam int G  = (NUM_SINKS + GROUP_SIZE - 1) / GROUP_SIZE;
    localparam int GW = $clog2(G) + 1;
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LAUNCH  = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;
    logic [2:0]           state, nxt;
    logic [DELAY_W-1:0]   cnt, cnt_n;
    logic [GW-1:0]        grp, grp_n;
    logic [NUM_SINKS-1:0] cap_n;
    assign req_ready = state == IDLE;
    assign busy      = !req_ready;
    // grp is the group currently on cap_en; the enables are registered from
    // the next group so each one appears exactly in its capture cycle
    always_comb begin
        nxt   = state;
        cnt_n = cnt;
        grp_n = grp;
        case (state)
            IDLE: if (req_valid) begin
                nxt   = LAUNCH;
                cnt_n = cfg_delay;
                grp_n = '0;
            end
            LAUNCH:  nxt = cnt != '0 ? WAIT : CAPTURE;
            WAIT: begin
                cnt_n = cnt - DELAY_W'(1);
                nxt   = cnt == DELAY_W'(1) ? CAPTURE : WAIT;
            end
            CAPTURE: begin
                nxt   = grp == GW'(G - 1) ? DONE : CAPTURE;
                grp_n = grp == GW'(G - 1) ? grp : grp + GW'(1);
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort && state != IDLE)
            nxt = IDLE;
        for (int i = 0; i < NUM_SINKS; i++)
            cap_n[i] = nxt == CAPTURE && grp_n == GW'(i / GROUP_SIZE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            grp         <= '0;
            launch_en   <= 1'b0;
            launch_data <= '0;
            cap_en      <= '0;
            done        <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= cnt_n;
            grp       <= grp_n;
            launch_en <= nxt == LAUNCH;
            cap_en    <= cap_n;
            done      <= nxt == DONE;
            if (req_valid && req_ready)
                launch_data <= req_data;
        end
    end
endmodule

// File: tb/tb_fanout_capture_sched.sv
// tb_fanout_capture_sched: directed and randomized checks of fanout_capture_sched against a timeline model
module tb_fanout_capture_sched;
    localparam int WIDTH = 1;
    localparam int NS    = 11;
    localparam int GS    = 4;
    localparam int DW    = 4;
    localparam int G     = (NS + GS - 1) / GS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic abort = 1'b0;
    logic [WIDTH-1:0] req_data = '0;
    logic [DW-1:0] cfg_delay = '0;
    logic req_ready, launch_en, busy, done;
    logic [WIDTH-1:0] launch_data;
    logic [NS-1:0] cap_en;

    int n_cmp = 0;
    int n_bad = 0;

    fanout_capture_sched #(.WIDTH(WIDTH), .NUM_SINKS(NS), .GROUP_SIZE(GS), .DELAY_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .cfg_delay(cfg_delay), .abort(abort),
        .launch_en(launch_en), .launch_data(launch_data), .cap_en(cap_en),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: a sequence is the offset from its accept edge; every
    // output is a pure function of that offset and the sampled delay.
    logic m_act;
    int m_off, m_D;
    logic [WIDTH-1:0] m_ld;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= 1'b0;
            m_off <= 0;
            m_D   <= 0;
            m_ld  <= '0;
        end else if (m_act) begin
            if (abort || m_off >= 2 + m_D + G) m_act <= 1'b0;
            m_off <= m_off + 1;
        end else if (req_valid) begin
            m_act <= 1'b1;
            m_off <= 1;
            m_D   <= int'(cfg_delay);
            m_ld  <= req_data;
        end
    end

    function automatic logic [NS-1:0] grp_mask(input int k);
        logic [31:0] m;
        m = ((32'h1 << GS) - 32'h1) << (k * GS);
        return m[NS-1:0];
    endfunction

    function automatic logic [NS-1:0] exp_cap();
        if (m_act && m_off >= 2 + m_D && m_off <= 1 + m_D + G)
            return grp_mask(m_off - 2 - m_D);
        return '0;
    endfunction

    always @(negedge clk) begin
        chk("busy", busy, m_act);
        chk("req_ready", req_ready, !m_act);
        chk("launch_en", launch_en, m_act && m_off == 1);
        chk("done", done, m_act && m_off == 2 + m_D + G);
        chk("cap_en", cap_en, exp_cap());
        chk("launch_data", launch_data, m_ld);
    end

    // Called at a negedge while idle; returns at the negedge of offset 1.
    task automatic start_req(input logic [WIDTH-1:0] d, input logic [DW-1:0] dl);
        req_valid = 1'b1;
        req_data  = d;
        cfg_delay = dl;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: req_ready stayed 0 after %0d cycles", n);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_cap", cap_en, 0);
        chk("rst_ld", launch_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_launch", launch_en, 0);

        start_req(1'b1, 4'd3);
        for (int off = 1; off <= 9; off++) begin
            if (off > 1) @(negedge clk);
            chk("t1_launch", launch_en, off == 1);
            chk("t1_cap", cap_en, off == 5 ? 11'h00F : off == 6 ? 11'h0F0 : off == 7 ? 11'h700 : 11'h000);
            chk("t1_done", done, off == 8);
            chk("t1_ready", req_ready, off == 9);
            chk("t1_ld", launch_data, 1);
        end

        start_req(1'b0, 4'd0);
        chk("d0_launch", launch_en, 1);
        @(negedge clk);
        chk("d0_cap", cap_en, 11'h00F);
        repeat (3) @(negedge clk);
        chk("d0_done", done, 1);
        @(negedge clk);

        start_req(1'b1, 4'd15);
        repeat (15) @(negedge clk);
        chk("d15_cap16", cap_en, 0);
        @(negedge clk);
        chk("d15_cap17", cap_en, 11'h00F);
        wait_idle();

        start_req(1'b1, 4'd3);
        repeat (5) @(negedge clk);
        chk("ab_cap6", cap_en, 11'h0F0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_cap7", cap_en, 0);
        chk("ab_done", done, 0);
        chk("ab_ready", req_ready, 1);
        chk("ab_ld", launch_data, 1);
        start_req(1'b0, 4'd2);
        chk("ab_relaunch", launch_en, 1);
        chk("ab_newld", launch_data, 0);
        repeat (6) @(negedge clk);
        chk("ab_newdone", done, 1);
        wait_idle();

        req_valid = 1'b1;
        for (int i = 0; i < 120; i++) begin
            cfg_delay = DW'($urandom_range(0, 5));
            req_data  = WIDTH'($urandom);
            @(negedge clk);
        end
        req_valid = 1'b0;
        wait_idle();

        start_req(1'b1, 4'd3);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_cap", cap_en, 0);
        chk("ar_busy", busy, 0);
        chk("ar_launch", launch_en, 0);
        chk("ar_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_ld", launch_data, 0);
        chk("ar_idle", req_ready, 1);

        for (int i = 0; i < 3000; i++) begin
            req_valid = $urandom_range(0, 3) != 0;
            abort     = $urandom_range(0, 15) == 0;
            cfg_delay = DW'($urandom_range(0, 15));
            req_data  = WIDTH'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        abort = 1'b0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
